// File: rtl/divide_8_by_4_bit.sv
// Sequential restoring divider: 2N-bit dividend by N-bit divisor, one quotient
// bit per clock, with the start/stop handshake shared by the multiplier.
module divide_8_by_4_bit #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst_b,
  input  logic           start,
  input  logic [2*N-1:0] X,
  input  logic [N-1:0]   Y,
  output logic [2*N-1:0] Q,
  output logic [N-1:0]   R,
  output logic           stop,
  output logic           div_zero
);

  localparam int CW = $clog2(2*N+1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]     state;
  logic [2*N-1:0] dvd;
  logic [N-1:0]   dvs;
  logic [N-1:0]   pr;
  logic [CW-1:0]  count;

  logic [N:0]     pr_shift;
  logic [N:0]     diff;
  logic           q_bit;
  logic [N-1:0]   pr_next;
  logic [2*N-1:0] dvd_next;
  logic           accept;

  // One restoring step. The shifted remainder is N+1 bits wide and the
  // restored remainder is always below the divisor, so it is stored in N bits.
  // The sign of the trial subtraction doubles as the >= comparison.
  always_comb begin
    pr_shift = {pr, dvd[2*N-1]};
    diff     = pr_shift - {1'b0, dvs};
    q_bit    = ~diff[N];
    pr_next  = q_bit ? diff[N-1:0] : pr_shift[N-1:0];
    dvd_next = {dvd[2*N-2:0], q_bit};
  end

  assign accept = start && (state != RUN);

  // The dividend register also collects quotient bits at its LSB, so after 2N
  // steps it holds the full quotient.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state    <= IDLE;
      dvd      <= '0;
      dvs      <= '0;
      pr       <= '0;
      count    <= '0;
      Q        <= '0;
      R        <= '0;
      stop     <= 1'b0;
      div_zero <= 1'b0;
    end else if (accept) begin
      if (Y == '0) begin
        state    <= DONE;
        Q        <= '1;
        R        <= '0;
        stop     <= 1'b1;
        div_zero <= 1'b1;
        count    <= '0;
      end else begin
        state    <= RUN;
        dvd      <= X;
        dvs      <= Y;
        pr       <= '0;
        count    <= CW'(2*N);
        stop     <= 1'b0;
        div_zero <= 1'b0;
      end
    end else if (state == RUN) begin
      dvd   <= dvd_next;
      pr    <= pr_next;
      count <= count - CW'(1);
      if (count == CW'(1)) begin
        Q        <= dvd_next;
        R        <= pr_next;
        stop     <= 1'b1;
        div_zero <= 1'b0;
        state    <= DONE;
      end
    end
  end

endmodule
